div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one sequential 64/32 signed divider (`div`) between `NUM_REQ` requesters, such as the quadrature-arctan angle stage and the de-emphasis/gain normalisation stage of the FM demodulator.
- Grants requesters round-robin and sequences the divider's `valid_in`/`valid_out` protocol.
- Tracks ownership of the single in-flight operation.
- Returns the registered result to the owning requester.
- Divide-by-zero requests are short-circuited without occupying the divider.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `DIVIDEND_WIDTH`, 64: dividend and quotient width.
- `DIVISOR_WIDTH`, 32: divisor and remainder width.
- `TIMEOUT_CYCLES`, 256: watchdog limit, used only when `DIV_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request strobe; held with operands until accepted.
- `req_dividend`  in  NUM_REQ×DIVIDEND_WIDTH  signed dividends.
- `req_divisor`  in  NUM_REQ×DIVISOR_WIDTH  signed divisors.
- `req_ready`  out  NUM_REQ  one-hot; high only for the granted requester while IDLE.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse to the owner.
- `rsp_quotient`  out  DIVIDEND_WIDTH  registered result, held until the next response.
- `rsp_remainder`  out  DIVISOR_WIDTH  registered result, held until the next response.
- `rsp_overflow`  out  1  registered result, held until the next response.
- `div_valid_in`  out  1  start pulse to the divider.
- `div_dividend`  out  DIVIDEND_WIDTH  latched operand to the divider.
- `div_divisor`  out  DIVISOR_WIDTH  latched operand to the divider.
- `div_quotient`  in  DIVIDEND_WIDTH  divider result.
- `div_remainder`  in  DIVISOR_WIDTH  divider result.
- `div_overflow`  in  1  divider result.
- `div_valid_out`  in  1  divider result strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_timeout`  out  1  sticky watchdog flag; tied 0 when the macro is undefined.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Round-robin search of `req_valid`, starting at pointer `rr_ptr`; the first valid index is granted and its `req_ready` is driven combinationally.
  - On handshake: latch operands into `div_dividend`/`div_divisor` and the owner index.
  - Divisor == 0: go to RESPOND with quotient = all ones, remainder = 0, overflow = 1.
  - Otherwise go to ISSUE.
- ISSUE: `div_valid_in`=1 for exactly one cycle, then go to WAIT.
- WAIT: on `div_valid_out`, capture quotient, remainder and overflow into the response registers, then go to RESPOND.
- RESPOND:
  - `rsp_valid[owner]`=1.
  - `rr_ptr` ← (owner+1) mod NUM_REQ.
  - Go to IDLE.
- Only one operation is in flight. Requests arriving meanwhile simply wait with `req_ready`=0.
- `div_valid_out` outside WAIT is ignored.
- A requester may reassert `req_valid` in the cycle after its `rsp_valid`. It gets the grant only if no higher round-robin index is valid.
- Reset values:
  - state = IDLE, `rr_ptr` = 0.
  - All operand and response registers = 0.
  - `rsp_valid`, `req_ready`, `div_valid_in`, `busy` and `err_timeout` = 0.
- Reset mid-operation: returns to IDLE immediately and drops the in-flight result. The divider shares the same reset.

## Timing
- Handshake at edge E0 → ISSUE during cycle E0+1 → WAIT from E0+2.
- If `div_valid_out` is sampled at edge Ek, `rsp_valid` is high during the following cycle. Overhead is 3 cycles beyond the divider latency.
- Divide-by-zero path: `rsp_valid` is high in the cycle after the handshake edge.
- Minimum back-to-back spacing between accepts is 4 cycles plus the divider latency.
- Outputs `div_*`, `rsp_*` and `busy` are registered or state-decoded. `req_ready` is combinational from `req_valid`, `rr_ptr` and the state.

## Configuration
- `DIV_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After `TIMEOUT_CYCLES` cycles without `div_valid_out`, go to RESPOND with quotient = all ones, remainder = 0, overflow = 1, and set `err_timeout` (cleared only by reset).
- Undefined: no counter is present, WAIT waits indefinitely, and `err_timeout` is tied 0.

## Structure
- `div_arb_pkg` holds:
  - `div_arb_state_t` enum {IDLE, ISSUE, WAIT, RESPOND}.
  - The divide-by-zero quotient/remainder constants.
  - The `TIMEOUT_CYCLES` default.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

## Test plan
- Single request: req0 100000<<10 / 300 → one `rsp_valid[0]` pulse with quotient 341333, remainder 100, `div_valid_in` pulsed exactly once.
- Contention: req0 and req1 both held from reset → grants alternate 0,1,0,1 across 4 operations. Each `rsp_valid` goes only to the owner.
- Divisor 0 on req1 → `rsp_valid[1]` the cycle after accept with quotient all ones, remainder 0, overflow 1, and `div_valid_in` never asserted.
- Negative operands: −7168 / 7 → quotient −1024, remainder 0, overflow 0, sign-correct over the full 64 bits.
- Reset asserted during WAIT → all outputs 0 next cycle and no `rsp_valid`. A fresh request afterwards completes normally.
- With `DIV_ARB_TIMEOUT_EN` and a stub divider that never answers → `rsp_valid` exactly 258 cycles after accept, overflow 1, `err_timeout` sticky.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared state type and constants for div_arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} div_arb_state_t;

  // Divide-by-zero and timeout responses: quotient all ones, remainder zero, overflow set.
  localparam logic DZ_QUOTIENT_BIT  = 1'b1;
  localparam logic DZ_REMAINDER_BIT = 1'b0;
  localparam logic DZ_OVERFLOW      = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[PTR_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        gnt                                          = '0;
        gnt[PTR_W'((int'(rr_ptr) + i) % NUM_REQ)]    = 1'b1;
        gnt_idx                                      = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential signed divider between NUM_REQ requesters, round-robin.
// Define DIV_ARB_TIMEOUT_EN to add a WAIT watchdog that sets a sticky err_timeout.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0]  req_dividend,
  input  logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [DIVIDEND_WIDTH-1:0]               rsp_quotient,
  output logic [DIVISOR_WIDTH-1:0]                rsp_remainder,
  output logic                                    rsp_overflow,
  output logic                                    div_valid_in,
  output logic [DIVIDEND_WIDTH-1:0]               div_dividend,
  output logic [DIVISOR_WIDTH-1:0]                div_divisor,
  input  logic [DIVIDEND_WIDTH-1:0]               div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]                div_remainder,
  input  logic                                    div_overflow,
  input  logic                                    div_valid_out,
  output logic                                    busy,
  output logic                                    err_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  div_arb_state_t            state_q, state_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic [NUM_REQ-1:0]        gnt;
  logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d, quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d, rem_q, rem_d;
  logic                      ovf_q, ovf_d;
  logic                      timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  // Down-counter armed in ISSUE so WAIT lasts at most TIMEOUT_CYCLES cycles.
  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q;
    if (state_q == ISSUE) begin
      tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == WAIT && tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign timeout     = (state_q == WAIT) && !div_valid_out && (tmr_q == '0);
  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d    = gnt_idx;
          dividend_d = req_dividend[gnt_idx];
          divisor_d  = req_divisor[gnt_idx];
          if (req_divisor[gnt_idx] == '0) begin
            quot_d  = {DIVIDEND_WIDTH{DZ_QUOTIENT_BIT}};
            rem_d   = {DIVISOR_WIDTH{DZ_REMAINDER_BIT}};
            ovf_d   = DZ_OVERFLOW;
            state_d = RESPOND;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_valid_out) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          ovf_d   = div_overflow;
          state_d = RESPOND;
        end else if (timeout) begin
          quot_d  = {DIVIDEND_WIDTH{DZ_QUOTIENT_BIT}};
          rem_d   = {DIVISOR_WIDTH{DZ_REMAINDER_BIT}};
          ovf_d   = DZ_OVERFLOW;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESPOND) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  // Ready is held low while reset is asserted, even though IDLE is the reset state.
  assign req_ready     = (state_q == IDLE && !reset) ? gnt : '0;
  assign div_valid_in  = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_overflow  = ovf_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider stub, round-robin reference
// model, directed cases plus randomised traffic.
module tb_div_arbiter;

  localparam int N  = 3;
  localparam int IW = $clog2(N);
  localparam int DW = 64;
  localparam int VW = 32;
  localparam int TO = 256;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           req_valid;
  logic [N-1:0][DW-1:0]   req_dividend;
  logic [N-1:0][VW-1:0]   req_divisor;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           rsp_valid;
  logic [DW-1:0]          rsp_quotient;
  logic [VW-1:0]          rsp_remainder;
  logic                   rsp_overflow;
  logic                   div_valid_in;
  logic [DW-1:0]          div_dividend;
  logic [VW-1:0]          div_divisor;
  logic [DW-1:0]          div_quotient;
  logic [VW-1:0]          div_remainder;
  logic                   div_overflow;
  logic                   div_valid_out;
  logic                   busy;
  logic                   err_timeout;

  div_arbiter #(
    .NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_overflow(rsp_overflow),
    .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_overflow(div_overflow),
    .div_valid_out(div_valid_out),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Divider stub: answers lat cycles after seeing div_valid_in, unless silent.
  int  stub_lat = 1;
  int  stub_cnt = 0;
  bit  stub_silent = 1'b0;
  int  stub_done_cyc = -1;
  logic signed [63:0] s_a, s_b;

  initial begin
    div_valid_out = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    div_overflow  = 1'b0;
    forever begin
      @(negedge clk);
      div_valid_out = 1'b0;
      if (reset) begin
        stub_cnt = 0;
      end else if (div_valid_in) begin
        s_a = div_dividend;
        s_b = {{32{div_divisor[31]}}, div_divisor};
        stub_cnt = stub_silent ? 0 : stub_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          div_quotient  = s_a / s_b;
          div_remainder = 32'(s_a % s_b);
          div_overflow  = (s_a == 64'sh8000_0000_0000_0000) && (s_b == -64'sd1);
          div_valid_out = 1'b1;
          stub_done_cyc = cyc;
        end
      end
    end
  end

  // Reference model: pointer to the index after the last owner.
  int m_ptr = 0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    return (o < 0) ? '0 : (N'(1) << o);
  endfunction

  task automatic set_req(input int i, input logic signed [63:0] a, input logic signed [31:0] b);
    logic [IW-1:0] ix;
    ix = IW'(i);
    req_valid[ix]    = 1'b1;
    req_dividend[ix] = a;
    req_divisor[ix]  = b;
  endtask

  task automatic new_req(input int i);
    logic signed [63:0] a;
    logic signed [31:0] b;
    case ($urandom_range(0, 2))
      0:       a = {$urandom, $urandom};
      1:       a = 64'($signed($urandom_range(0, 2000)) - 1000);
      default: a = {{32{1'b0}}, $urandom};
    endcase
    case ($urandom_range(0, 5))
      0:       b = 32'sd0;
      1:       b = 32'($signed($urandom_range(1, 50)) * ($urandom_range(0, 1) ? 1 : -1));
      default: b = $urandom;
    endcase
    if (b == -32'sd1) b = 32'sd3;
    set_req(i, a, b);
  endtask

  // Assumes inputs were just driven at a negedge; completes one accept and response.
  task automatic run_op(input int lat, output int owner);
    int exp_o, n_issue, n_ready, waited;
    logic [IW-1:0] ix;
    logic signed [63:0] a, bx, eq;
    logic [31:0] er;
    logic eo;
    logic [N-1:0] oh;
    stub_lat = lat;
    #1;
    exp_o = pick(req_valid, m_ptr);
    owner = exp_o;
    oh = onehot(exp_o);
    check("grant", req_ready, oh);
    check("busy_idle", busy, 1'b0);
    if (exp_o < 0) return;
    ix = IW'(exp_o);
    a  = req_dividend[ix];
    bx = {{32{req_divisor[ix][31]}}, req_divisor[ix]};
    if (bx == 0) begin
      eq = '1; er = '0; eo = 1'b1;
    end else begin
      eq = a / bx; er = 32'(a % bx); eo = 1'b0;
    end
    @(negedge clk);
    req_valid[ix] = 1'b0;
    check("latched_dividend", div_dividend, a);
    check("latched_divisor", div_divisor, bx[31:0]);
    check("busy_active", busy, 1'b1);
    if (bx == 0) begin
      check("dz_no_issue", div_valid_in, 1'b0);
    end else begin
      check("issue", div_valid_in, 1'b1);
      n_issue = 0; n_ready = 0; waited = 0;
      do begin
        @(negedge clk);
        waited++;
        n_issue += int'(div_valid_in);
        n_ready += int'(req_ready != '0);
      end while (rsp_valid == '0 && waited < 2000);
      check("rsp_in_budget", waited < 2000, 1'b1);
      check("rsp_latency", cyc, stub_done_cyc + 1);
      check("single_issue", n_issue, 0);
      check("ready_while_busy", n_ready, 0);
    end
    check("rsp_owner", rsp_valid, oh);
    check("rsp_quotient", rsp_quotient, eq);
    check("rsp_remainder", rsp_remainder, er);
    check("rsp_overflow", rsp_overflow, eo);
    m_ptr = (exp_o + 1) % N;
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, '0);
    check("busy_released", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int o, n0, waited, n_rsp, n_busy;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check("rst_ready", req_ready, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_div_valid_in", div_valid_in, 1'b0);
    check("rst_div_dividend", div_dividend, '0);
    check("rst_div_divisor", div_divisor, '0);
    check("rst_rsp_quotient", rsp_quotient, '0);
    check("rst_rsp_remainder", rsp_remainder, '0);
    check("rst_rsp_overflow", rsp_overflow, 1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;

    // Single request on req0.
    set_req(0, 64'sd100000 <<< 10, 32'sd300);
    run_op(5, o);
    check("single_owner", o, 0);
    check("single_quotient", rsp_quotient, 64'd341333);
    check("single_remainder", rsp_remainder, 32'd100);

    // Stray div_valid_out while idle must be ignored.
    #1 div_valid_out = 1'b1;
    @(negedge clk);
    #1;
    check("stray_rsp_valid", rsp_valid, '0);
    check("stray_busy", busy, 1'b0);
    check("stray_quotient_held", rsp_quotient, 64'd341333);
    @(negedge clk);

    // Divide by zero on req1.
    set_req(1, 64'sd12345, 32'sd0);
    run_op(1, o);
    check("dz_owner", o, 1);
    check("dz_quotient", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dz_overflow", rsp_overflow, 1'b1);

    // Negative operands.
    set_req(0, -64'sd7168, 32'sd7);
    run_op(3, o);
    check("neg_owner", o, 0);
    check("neg_quotient", rsp_quotient, 64'hFFFF_FFFF_FFFF_FC00);
    check("neg_remainder", rsp_remainder, 32'd0);
    check("neg_overflow", rsp_overflow, 1'b0);

    // Reset while the operation sits in WAIT.
    set_req(2, 64'sd1000, 32'sd3);
    stub_lat = 50;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_div_valid_in", div_valid_in, 1'b0);
    check("midrst_div_dividend", div_dividend, '0);
    check("midrst_div_divisor", div_divisor, '0);
    check("midrst_rsp_quotient", rsp_quotient, '0);
    check("midrst_rsp_overflow", rsp_overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    m_ptr = 0;
    n_rsp = 0; n_busy = 0;
    repeat (60) begin
      @(negedge clk);
      n_rsp  += int'(rsp_valid != '0);
      n_busy += int'(busy);
    end
    check("midrst_no_rsp", n_rsp, 0);
    check("midrst_stays_idle", n_busy, 0);
    set_req(1, 64'sd99, 32'sd9);
    run_op(3, o);
    check("post_reset_owner", o, 1);

    // Contention: req0 and req1 held from reset, alternating grants.
    reset = 1'b1;
    set_req(0, 64'sd500, 32'sd7);
    set_req(1, -64'sd500, 32'sd11);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < 4; k++) begin
      run_op($urandom_range(1, 6), o);
      check("alternate_owner", o, k % 2);
      set_req(o, 64'(k * 1000 + 17), 32'(k + 2));
    end
    req_valid = '0;
    @(negedge clk);

    // Randomised traffic.
    for (int op = 0; op < 150; op++) begin
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & N'(1)) == '0 && $urandom_range(0, 2) == 0) new_req(i);
      end
      if (req_valid == '0) new_req($urandom_range(0, N - 1));
      run_op($urandom_range(1, 12), o);
    end
    req_valid = '0;
    @(negedge clk);

`ifdef DIV_ARB_TIMEOUT_EN
    stub_silent = 1'b1;
    set_req(2, 64'sd5, 32'sd3);
    #1;
    o = pick(req_valid, m_ptr);
    check("to_grant", req_ready, onehot(o));
    n0 = cyc;
    @(negedge clk);
    req_valid = '0;
    waited = 0;
    while (rsp_valid == '0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("to_latency", cyc - n0, TO + 2);
    check("to_owner", rsp_valid, onehot(o));
    check("to_quotient", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_remainder", rsp_remainder, 32'd0);
    check("to_overflow", rsp_overflow, 1'b1);
    check("to_err", err_timeout, 1'b1);
    m_ptr = (o + 1) % N;
    stub_silent = 1'b0;
    @(negedge clk);
    set_req(0, 64'sd40, 32'sd6);
    run_op(2, o);
    check("to_err_sticky", err_timeout, 1'b1);
`else
    n0 = 0; waited = 0;
    check("err_timeout_tied", err_timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
